// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default Q format, word typedefs, saturation
// limits and the MAC/requant state encoding.
package fixed_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int INT_DEF    = 4;
  localparam int FRAC_DEF   = 4;
  localparam int LENGTH_DEF = 4;

  typedef logic signed [WIDTH_DEF-1:0]   q_t;
  typedef logic signed [2*WIDTH_DEF-1:0] prod_t;

  localparam q_t Q_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam q_t Q_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fixed_requant.sv
// Combinational round-half-up and saturate from a wide Q(2I).(2F) accumulator
// back to a WIDTH-bit Q(I).(F) word.
module fixed_requant #(
  parameter int WIDTH         = 8,
  parameter int FRACTIONWIDTH = 4,
  parameter int ACC_WIDTH     = 19
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [WIDTH-1:0]     out_data,
  output logic                        out_sat
);

  // One guard bit so adding the rounding offset can never wrap.
  localparam int RW = ACC_WIDTH + 1;

  localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (FRACTIONWIDTH - 1);
  localparam logic signed [RW-1:0] MAX_R = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [RW-1:0] biased_s;
  logic signed [RW-1:0] rounded_s;

  // Round half-up via offset plus arithmetic shift, then clamp to the word range.
  always_comb begin
    biased_s  = {sum[ACC_WIDTH-1], sum} + HALF;
    rounded_s = biased_s >>> FRACTIONWIDTH;
    out_data  = {WIDTH{1'b0}};
    out_sat   = 1'b0;
    if (rounded_s > MAX_R) begin
      out_data = SAT_HI;
      out_sat  = 1'b1;
    end else if (rounded_s < MIN_R) begin
      out_data = SAT_LO;
      out_sat  = 1'b1;
    end else begin
      out_data = rounded_s[WIDTH-1:0];
      out_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_mac_requant.sv
// Accumulates up to LENGTH signed products per vector, then holds the rounded,
// saturated sum on a valid/ready output until the consumer takes it.
module fixed_mac_requant
  import fixed_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int INTEGERWIDTH  = INT_DEF,
  parameter int FRACTIONWIDTH = FRAC_DEF,
  parameter int LENGTH        = LENGTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_product,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sat
);

  localparam int ACC_WIDTH = 2*WIDTH + $clog2(LENGTH) + 1;
  localparam int CNT_W     = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);
  // The integer width is authoritative if the three format parameters disagree.
  localparam int FRAC_W = (WIDTH == INTEGERWIDTH + FRACTIONWIDTH) ? FRACTIONWIDTH
                                                                  : WIDTH - INTEGERWIDTH;

  state_e                       state_r;
  state_e                       state_n;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic [CNT_W-1:0]             count_r;
  logic [WIDTH-1:0]             out_data_r;
  logic                         out_sat_r;

  logic                         accept_s;
  logic                         last_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic [WIDTH-1:0]             req_data_s;
  logic                         req_sat_s;

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == HOLD);
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

  assign accept_s = in_valid & in_ready;
  assign last_s   = accept_s & (in_last | (count_r == LAST_CNT));
  assign sum_s    = acc_r + {{(ACC_WIDTH-2*WIDTH){in_product[2*WIDTH-1]}}, in_product};

  fixed_requant #(
    .WIDTH         (WIDTH),
    .FRACTIONWIDTH (FRAC_W),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_requant (
    .sum      (sum_s),
    .out_data (req_data_s),
    .out_sat  (req_sat_s)
  );

  // Next-state: finish a vector on its last beat, release once output is taken.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ACCUM: begin
        if (last_s) state_n = HOLD;
        else        state_n = ACCUM;
      end
      HOLD: begin
        if (out_ready) state_n = ACCUM;
        else           state_n = HOLD;
      end
      default: state_n = ACCUM;
    endcase
  end

  // State, accumulator, beat counter and the registered result word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ACCUM;
      acc_r      <= '0;
      count_r    <= '0;
      out_data_r <= '0;
      out_sat_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        acc_r   <= sum_s;
        count_r <= count_r + CNT_W'(1);
        if (last_s) begin
          out_data_r <= req_data_s;
          out_sat_r  <= req_sat_s;
        end
      end else if (out_valid && out_ready) begin
        acc_r   <= '0;
        count_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mac_requant.sv
// Self-checking bench for fixed_mac_requant: directed scenarios plus random
// vectors compared against an integer-arithmetic reference model.
module tb_fixed_mac_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;

  int n_pass  = 0;
  int n_total = 0;

  fixed_mac_requant dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  // Reference: floor((S + 8) / 16), clamped to [-128, 127]; returns {sat, data}.
  function automatic logic [8:0] ref_q(input longint s);
    longint t;
    longint r;
    t = s + 64'sd8;
    if (t >= 0) r = t / 16;
    else        r = -((-t + 15) / 16);
    if (r > 127)       return {1'b1, 8'h7F};
    else if (r < -128) return {1'b1, 8'h80};
    else               return {1'b0, 8'(r)};
  endfunction

  task automatic drive(input logic v, input logic [15:0] p, input logic l);
    @(negedge clk);
    in_valid   = v;
    in_product = p;
    in_last    = l;
  endtask

  // Back-to-back beats; returns at the negedge one cycle after the last accept.
  task automatic feed(input logic [15:0] v[$], input logic use_last);
    for (int i = 0; i < v.size(); i++)
      drive(1'b1, v[i], (i == v.size() - 1) ? use_last : 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_product = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else n_pass++;
    n_total++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat got %b exp 0", out_sat); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0100, 1'b0);
      n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL nominal_beat%0d got ready=%b valid=%b exp ready=1 valid=0", i, in_ready, out_valid); else n_pass++;
    end
    drive(1'b0, 16'h0000, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL nominal_latency got valid=%b exp 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h40 || out_sat !== 1'b0)
      $display("FAIL nominal_result got %h/%b exp 40/0", out_data, out_sat); else n_pass++;
    consume();
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL nominal_release got valid=%b ready=%b exp 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_rounding();
    logic [15:0] firsts [4] = '{16'h0008, 16'h0007, 16'hFFF8, 16'hFFF7};
    logic [7:0]  exps   [4] = '{8'h01, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      feed('{firsts[i], 16'h0000, 16'h0000, 16'h0000}, 1'b0);
      n_total++; if (out_valid !== 1'b1 || out_data !== exps[i] || out_sat !== 1'b0)
        $display("FAIL rounding_%0d got v=%b %h/%b exp v=1 %h/0", i, out_valid, out_data, out_sat, exps[i]); else n_pass++;
      consume();
    end
  endtask

  task automatic test_saturation();
    feed('{16'h4000, 16'h4000, 16'h4000, 16'h4000}, 1'b0);
    n_total++; if (out_data !== 8'h7F || out_sat !== 1'b1)
      $display("FAIL sat_pos got %h/%b exp 7f/1", out_data, out_sat); else n_pass++;
    consume();
    feed('{16'hC000, 16'hC000, 16'hC000, 16'hC000}, 1'b0);
    n_total++; if (out_data !== 8'h80 || out_sat !== 1'b1)
      $display("FAIL sat_neg got %h/%b exp 80/1", out_data, out_sat); else n_pass++;
    consume();
  endtask

  task automatic test_early_end();
    feed('{16'h0100, 16'h0100}, 1'b1);
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h20 || out_sat !== 1'b0)
      $display("FAIL early_end got v=%b %h/%b exp v=1 20/0", out_valid, out_data, out_sat); else n_pass++;
    consume();
    feed('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 1'b0);
    n_total++; if (out_data !== 8'h40) $display("FAIL early_end_next got %h exp 40", out_data); else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    feed('{16'h0080, 16'h0080, 16'h0080, 16'h0080}, 1'b0);
    in_valid = 1'b1; in_product = 16'h0100; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h20)
        $display("FAIL bp_hold_%0d got ready=%b v=%b %h exp 0/1/20", i, in_ready, out_valid, out_data); else n_pass++;
    end
    out_ready = 1'b1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_consume_ready got %b exp 0", in_ready); else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_after got v=%b ready=%b exp 0/1", out_valid, in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    feed('{16'h0100, 16'h0100, 16'h0100}, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h40)
      $display("FAIL bp_held_beat got v=%b %h exp 1/40", out_valid, out_data); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0100, 1'b0);
    drive(1'b1, 16'h0100, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    do_reset();
    feed('{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_data !== 8'h40)
      $display("FAIL reset_mid_next got v=%b %h exp 1/40", out_valid, out_data); else n_pass++;
    // Assert reset between edges while holding a result.
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_data !== 8'h00)
      $display("FAIL reset_async got v=%b %h exp 0/00", out_valid, out_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int          len;
      longint      s;
      logic [15:0] p;
      logic [8:0]  e;
      len = $urandom_range(1, 4);
      s   = 0;
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0) drive(1'b0, 16'($urandom), 1'($urandom));
        if ($urandom_range(0, 1) == 1) p = 16'($urandom);
        else                           p = 16'($urandom_range(0, 16'h01FF)) - 16'h0100;
        s = s + longint'($signed(p));
        drive(1'b1, p, (i == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom)) : 1'b0);
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
          $display("FAIL rand_%0d_beat%0d got ready=%b v=%b exp 1/0", n, i, in_ready, out_valid); else n_pass++;
      end
      drive(1'b0, 16'($urandom), 1'b0);
      e = ref_q(s);
      for (int w = $urandom_range(0, 3); w >= 0; w--) begin
        n_total++; if (out_valid !== 1'b1 || out_data !== e[7:0] || out_sat !== e[8])
          $display("FAIL rand_%0d got v=%b %h/%b exp v=1 %h/%b", n, out_valid, out_data, out_sat, e[7:0], e[8]); else n_pass++;
        if (w > 0) @(negedge clk);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rounding();
    test_saturation();
    test_early_end();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
